seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Programmable serial pattern-detection controller. It accepts parallel frames over a valid/ready handshake and serialises each frame LSB-first into an internal configurable pattern detector (up to PAT_MAX bits). For every bit it drives the serial bit `x` and the per-bit match pulse `z`, counts matches per frame, and signals completion. It sits between a frame source and downstream match logic, and sequences and configures the shared detector datapath.

## Interface
- `FRAME_W`, 16: bits per frame.
- `PAT_MAX`, 8: maximum pattern length.
- `CNT_W`, 5: match counter width; must hold FRAME_W.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_we` in 1: configuration write strobe.
- `cfg_pattern` in PAT_MAX: pattern; bit [cfg_len-1] = oldest bit, bit [0] = newest.
- `cfg_len` in 4: pattern length, legal 1..PAT_MAX.
- `in_valid` in 1: frame offered.
- `in_ready` out 1: frame accepted when `in_valid && in_ready` at a rising edge.
- `in_frame` in FRAME_W: frame data, bit 0 sent first.
- `x` out 1: serial bit consumed at the last edge (registered).
- `z` out 1: match pulse for that bit (registered, aligned with `x`).
- `busy` out 1: state is SHIFT.
- `done` out 1: one-cycle frame-complete pulse.
- `match_count` out CNT_W: matches in the current/last frame.
- `cfg_err` out 1: one-cycle pulse on a rejected config write.

## Operation
- States: IDLE, SHIFT, DONE. Reset forces IDLE, clears pattern, length, config-valid flag, history, fill count, bit index, `match_count`, and sets `x`=`z`=`done`=`cfg_err`=0.
- Config write in IDLE with `cfg_len` in 1..PAT_MAX: latch pattern and length, set config-valid.
- Config write in IDLE with `cfg_len` = 0 or > PAT_MAX: pulse `cfg_err`; config unchanged.
- Config write outside IDLE: pulse `cfg_err`; config unchanged.
- `in_ready` = IDLE && config-valid && !`cfg_we`. A config write has priority over a simultaneous frame offer.
- Accept (IDLE→SHIFT): latch frame; clear history, fill count, bit index and `match_count`.
- SHIFT, per edge:
  - Take bit b = frame[idx]; hist ← {hist[PAT_MAX-2:0], b}; fill ← min(fill+1, PAT_MAX); `x` ← b.
  - Match when fill(after) ≥ cfg_len and hist[cfg_len-1:0] == cfg_pattern[cfg_len-1:0]. On a match, `z` ← 1 and `match_count` increments; otherwise `z` ← 0.
  - idx increments. After bit FRAME_W-1 the state moves to DONE.
- DONE: `done` = 1 for one cycle, then IDLE. `z` ← 0. `match_count` holds until the next accept.
- Overlap behaviour is set by the configuration macro (see Configuration).
- Reset mid-frame aborts the frame with no `done` and clears the configuration.

## Timing
- Accept at edge E0. Bit i is processed at edge E(i+1), and `x`/`z` for bit i are valid in the cycle after E(i+1).
- Last bit at E(FRAME_W). `done` and `busy`=0 hold for the cycle after E(FRAME_W). State returns to IDLE at E(FRAME_W+1).
- Earliest next accept is E(FRAME_W+2); throughput is one frame per FRAME_W+2 cycles.
- `match_count` is final while `done`=1.
- `in_ready`, `busy` and `done` are decoded from state; all other outputs are registered.
- `cfg_err` is high in the cycle after the offending write.

## Configuration
- `SEQ_DETECT_OVERLAP_EN` defined: overlapping matches counted; history is retained after a match.
- Not defined: non-overlapping. On a match, the fill count resets to 0, so the next match needs cfg_len fresh bits.

## Test plan
- **Unconfigured after reset:** reset 2 cycles, `in_valid`=1 → `in_ready`=0 and all outputs 0.
- **Overlap count (macro defined):** cfg_len=4, cfg_pattern=8'h06, in_frame=16'h066C → `z` pulses for bits 4, 7 and 11; `match_count`=3 at `done`; `done` 17 cycles after accept.
- **Non-overlap count (macro undefined):** same stimulus → `z` for bits 4 and 11 only; `match_count`=2.
- **Length-1 pattern:** cfg_len=1, cfg_pattern=1, in_frame=16'hFFFF → `z` high for 16 consecutive cycles; `match_count`=16 in both configurations.
- **Illegal config writes:** cfg_len=0 in IDLE → `cfg_err` pulse, prior config kept. `cfg_we` during SHIFT → `cfg_err` pulse, frame result unaffected. `cfg_we` and `in_valid` together in IDLE → config taken, `in_ready`=0 that cycle.
- **Reset mid-frame:** reset at bit 5 of a frame → next cycle IDLE, `match_count`=0, no `done`, `in_ready`=0 until reconfigured.

Source files
------------

// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: frame handshake and configuration bus for seq_detect_ctrl
interface seq_detect_ctrl_if #(
    parameter int FRAME_W = 16,
    parameter int PAT_MAX = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [FRAME_W-1:0] in_frame;
    logic               cfg_we;
    logic [PAT_MAX-1:0] cfg_pattern;
    logic [3:0]         cfg_len;
    modport master (output in_valid, in_frame, cfg_we, cfg_pattern, cfg_len, input in_ready);
    modport slave  (input in_valid, in_frame, cfg_we, cfg_pattern, cfg_len, output in_ready);
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: serialises frames LSB-first into a programmable pattern detector; SEQ_DETECT_OVERLAP_EN enables overlapping matches
module seq_detect_ctrl #(
    parameter int FRAME_W = 16,
    parameter int PAT_MAX = 8,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             reset,
    seq_detect_ctrl_if.slave bus,
    output logic             x,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);
    localparam int IW = $clog2(FRAME_W);
    localparam logic [3:0] PMAX = 4'(PAT_MAX);
    localparam logic [IW-1:0] LAST = IW'(FRAME_W - 1);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [PAT_MAX-1:0] pat, hist_n, mask;
    logic [PAT_MAX-2:0] hist;
    logic [3:0] len, fill, fill_n;
    logic [FRAME_W-1:0] frame;
    logic [IW-1:0] idx;
    logic cfg_ok, cfg_take, accept, bit_in, hit;
    // handshake decode, detector compare and next-state selection
    always_comb begin
        cfg_take = bus.cfg_we && state == IDLE && bus.cfg_len != 4'd0 && bus.cfg_len <= PMAX;
        bus.in_ready = state == IDLE && cfg_ok && !bus.cfg_we;
        accept = bus.in_valid && bus.in_ready;
        busy = state == SHIFT;
        done = state == DONE;
        bit_in = frame[idx];
        hist_n = {hist, bit_in};
        fill_n = fill == PMAX ? fill : fill + 4'd1;
        mask = ~({PAT_MAX{1'b1}} << len);
        hit = fill_n >= len && ((hist_n ^ pat) & mask) == '0;
        state_n = state == IDLE ? (accept ? SHIFT : IDLE) :
                  state == SHIFT ? (idx == LAST ? DONE : SHIFT) : IDLE;
    end
    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // configuration, frame capture and per-bit detector datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            pat <= '0;
            len <= '0;
            cfg_ok <= 1'b0;
            hist <= '0;
            fill <= '0;
            idx <= '0;
            frame <= '0;
            match_count <= '0;
            x <= 1'b0;
            z <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= bus.cfg_we && !cfg_take;
            z <= 1'b0;
            if (cfg_take) begin
                pat <= bus.cfg_pattern;
                len <= bus.cfg_len;
                cfg_ok <= 1'b1;
            end
            if (accept) begin
                frame <= bus.in_frame;
                hist <= '0;
                fill <= '0;
                idx <= '0;
                match_count <= '0;
            end
            if (state == SHIFT) begin
                hist <= hist_n[PAT_MAX-2:0];
`ifdef SEQ_DETECT_OVERLAP_EN
                fill <= fill_n;
`else
                fill <= hit ? 4'd0 : fill_n;
`endif
                x <= bit_in;
                z <= hit;
                match_count <= match_count + CNT_W'(hit);
                idx <= idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: table vectors, corner sequences and random frames against a window-compare model
module tb_seq_detect_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x, z, busy, done, cfg_err;
    logic [4:0] match_count;
    int n_chk = 0;
    int n_fail = 0;
    seq_detect_ctrl_if #(.FRAME_W(16), .PAT_MAX(8)) bus ();
    seq_detect_ctrl #(.FRAME_W(16), .PAT_MAX(8), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .bus(bus), .x(x), .z(z), .busy(busy),
        .done(done), .match_count(match_count), .cfg_err(cfg_err)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0]  len;
        logic [7:0]  pat;
        logic [15:0] frame;
        logic [15:0] z_ov;
        logic [15:0] z_no;
        int          c_ov;
        int          c_no;
    } vec_t;
    vec_t tbl[7];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    // reference: bit i matches if the last len frame bits equal the pattern and enough fresh bits exist
    task automatic model(input int len, input logic [7:0] pat, input logic [15:0] f,
                         output logic [15:0] zm, output int cnt);
        int last = -1;
        zm = '0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            bit ok;
`ifdef SEQ_DETECT_OVERLAP_EN
            ok = i + 1 >= len;
`else
            ok = i - last >= len;
`endif
            for (int k = 0; k < len; k++)
                if (ok && f[i-k] != pat[k]) ok = 0;
            if (ok) begin
                zm[i] = 1'b1;
                cnt++;
                last = i;
            end
        end
    endtask
    task automatic do_cfg(input string name, input logic [3:0] len, input logic [7:0] pat, input logic exp_err);
        bus.cfg_we = 1'b1;
        bus.cfg_len = len;
        bus.cfg_pattern = pat;
        tick;
        bus.cfg_we = 1'b0;
        chk(name, cfg_err, exp_err);
    endtask
    task automatic frame_check(input string name, input logic [15:0] f, input logic [15:0] exp_z,
                               input int exp_cnt, input int cfg_at);
        logic [15:0] zm, xm;
        logic early, err;
        bus.in_frame = f;
        bus.in_valid = 1'b1;
        #1;
        chk({name, "_ready"}, bus.in_ready, 1);
        tick;
        bus.in_valid = 1'b0;
        zm = '0;
        xm = '0;
        early = 1'b0;
        err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == cfg_at) begin
                bus.cfg_we = 1'b1;
                bus.cfg_len = 4'd1;
                bus.cfg_pattern = 8'h01;
            end
            tick;
            bus.cfg_we = 1'b0;
            zm[i] = z;
            xm[i] = x;
            if (i < 15 && (done || !busy)) early = 1'b1;
            if (i == cfg_at) err = cfg_err;
        end
        chk({name, "_z"}, zm, exp_z);
        chk({name, "_x"}, xm, f);
        chk({name, "_busy_until_last"}, early, 0);
        chk({name, "_done"}, {busy, done}, 2'b01);
        chk({name, "_count"}, match_count, exp_cnt);
        if (cfg_at >= 0) chk({name, "_cfg_err_shift"}, err, 1);
        tick;
        chk({name, "_done_drop"}, {done, z}, 2'b00);
    endtask
    initial begin
        logic [15:0] ez, f;
        logic [7:0] p;
        int ec, l, seen;
        tbl[0] = '{4'd4, 8'h06, 16'h066C, 16'h0890, 16'h0810, 3, 2};
        tbl[1] = '{4'd1, 8'h01, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16, 16};
        tbl[2] = '{4'd1, 8'h00, 16'h0000, 16'hFFFF, 16'hFFFF, 16, 16};
        tbl[3] = '{4'd2, 8'h03, 16'hFFFF, 16'hFFFE, 16'hAAAA, 15, 8};
        tbl[4] = '{4'd8, 8'hFF, 16'hFFFF, 16'hFF80, 16'h8080, 9, 2};
        tbl[5] = '{4'd3, 8'h05, 16'h0000, 16'h0000, 16'h0000, 0, 0};
        tbl[6] = '{4'd3, 8'h05, 16'h5555, 16'h5554, 16'h4444, 7, 4};
        bus.in_valid = 1'b1;
        bus.in_frame = 16'hA5A5;
        bus.cfg_we = 1'b0;
        bus.cfg_len = 4'd0;
        bus.cfg_pattern = 8'h00;
        tick;
        tick;
        chk("reset_outputs", {bus.in_ready, x, z, busy, done, cfg_err, match_count}, 0);
        reset = 1'b0;
        tick;
        chk("unconfigured_ready", {bus.in_ready, busy}, 0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
`ifdef SEQ_DETECT_OVERLAP_EN
            ez = tbl[i].z_ov;
            ec = tbl[i].c_ov;
`else
            ez = tbl[i].z_no;
            ec = tbl[i].c_no;
`endif
            do_cfg($sformatf("tbl%0d_cfg", i), tbl[i].len, tbl[i].pat, 0);
            frame_check($sformatf("tbl%0d", i), tbl[i].frame, ez, ec, -1);
        end
`ifdef SEQ_DETECT_OVERLAP_EN
        ez = tbl[0].z_ov;
        ec = tbl[0].c_ov;
`else
        ez = tbl[0].z_no;
        ec = tbl[0].c_no;
`endif
        do_cfg("cfg_ok", 4'd4, 8'h06, 0);
        do_cfg("cfg_len0", 4'd0, 8'hFF, 1);
        tick;
        chk("cfg_err_pulse_drop", cfg_err, 0);
        do_cfg("cfg_len9", 4'd9, 8'hFF, 1);
        frame_check("kept_cfg", 16'h066C, ez, ec, -1);
        frame_check("cfg_in_shift", 16'h066C, ez, ec, 6);
        frame_check("after_shift_cfg", 16'h066C, ez, ec, -1);
        bus.cfg_we = 1'b1;
        bus.cfg_len = 4'd3;
        bus.cfg_pattern = 8'h05;
        bus.in_valid = 1'b1;
        bus.in_frame = 16'h5555;
        #1;
        chk("cfg_prio_ready", bus.in_ready, 0);
        tick;
        bus.cfg_we = 1'b0;
        chk("cfg_prio_taken", {busy, cfg_err}, 0);
`ifdef SEQ_DETECT_OVERLAP_EN
        frame_check("cfg_prio_frame", 16'h5555, tbl[6].z_ov, tbl[6].c_ov, -1);
`else
        frame_check("cfg_prio_frame", 16'h5555, tbl[6].z_no, tbl[6].c_no, -1);
`endif
        for (int r = 0; r < 25; r++) begin
            l = $urandom_range(1, 8);
            p = 8'($urandom);
            f = (r % 3 == 0) ? {8'($urandom) & 8'hF0, p} : 16'($urandom);
            model(l, p, f, ez, ec);
            do_cfg($sformatf("rnd%0d_cfg", r), 4'(l), p, 0);
            frame_check($sformatf("rnd%0d", r), f, ez, ec, -1);
        end
        do_cfg("mid_cfg", 4'd4, 8'h06, 0);
        bus.in_frame = 16'h066C;
        bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        repeat (5) tick;
        chk("mid_count_before", match_count, 1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("mid_reset_state", {busy, done, z, match_count}, 0);
        bus.in_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done || bus.in_ready || busy) seen++;
        end
        chk("mid_reset_no_done_ready", seen, 0);
        bus.in_valid = 1'b0;
        do_cfg("recfg", 4'd1, 8'h01, 0);
        frame_check("after_reset", 16'hFFFF, 16'hFFFF, 16, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
